// File: rtl/term_host_master.sv
// term_host_master
//
// Host-side Avalon-MM master that feeds a batch of IEEE-754 samples into a
// term accumulator slave and reads the accumulated result back.
// A batch clears the slave (address 1, data 0), writes each sample to
// address 0 with a fixed idle gap between writes, waits for the slave pipeline
// to drain, then reads address 1 and presents the result on res_data.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start, count      begin a batch of count samples (sampled only in IDLE)
//   s_valid, s_data   sample stream in; s_ready acknowledges an accept
//   avm_*             single-bit-address Avalon-MM master to the term slave
//   busy              high whenever the controller is not IDLE
//   res_valid         one-cycle pulse; res_data holds the result until the next
//   err               one-cycle stall-timeout pulse
//
// Build option: define TERM_HOST_TIMEOUT_EN to abort a batch after
// TIMEOUT_CYCLES consecutive FEED cycles without a sample. Without it err is
// tied low and FEED waits indefinitely.
//
// WRITE_GAP, DRAIN_CYCLES, READ_LATENCY and TIMEOUT_CYCLES must all be >= 1.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | one-cycle clear write to the result register
// FEED    | waiting for / accepting the next sample
// GAP     | WRITE_GAP idle cycles between sample writes
// DRAIN   | DRAIN_CYCLES idle cycles after the last sample write
// READ    | one-cycle read strobe on the result register
// WAIT_RD | waiting READ_LATENCY edges for the read data
// DONE    | one-cycle res_valid pulse

module term_host_master #(
   parameter int WRITE_GAP      = 7,
   parameter int DRAIN_CYCLES   = 12,
   parameter int READ_LATENCY   = 11,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] count,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic        avm_address,
   output logic        avm_write,
   output logic        avm_read,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        err
);

   if (WRITE_GAP < 1 || DRAIN_CYCLES < 1 || READ_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("term_host_master: timing parameters must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_GAP, S_DRAIN, S_READ, S_WAIT_RD, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] remaining;
   logic [15:0] tmr;
   logic        accept;
   logic        stall_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      s_ready       = 1'b0;
      avm_address   = 1'b0;
      avm_write     = 1'b0;
      avm_read      = 1'b0;
      avm_writedata = 32'h0;
      busy          = (state != S_IDLE);
      res_valid     = 1'b0;
      accept        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            avm_write   = 1'b1;
            avm_address = 1'b1;
            state_nxt   = (remaining == 16'd0) ? S_DONE : S_FEED;
         end
         S_FEED: begin
            s_ready = s_valid;
            if (s_valid) begin
               accept        = 1'b1;
               avm_write     = 1'b1;
               avm_writedata = s_data;
               state_nxt     = (remaining == 16'd1) ? S_DRAIN : S_GAP;
            end else if (stall_hit) begin
               state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            if (tmr == 16'd0) state_nxt = S_FEED;
         end
         S_DRAIN: begin
            if (tmr == 16'd0) state_nxt = S_READ;
         end
         S_READ: begin
            avm_read    = 1'b1;
            avm_address = 1'b1;
            state_nxt   = S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (tmr == 16'd0) state_nxt = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Shared down-counter: loaded with (length - 1) on entry to a timed state,
   // so the state exits on the cycle the counter reads zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr <= 16'd0;
      end else if (state_nxt != state) begin
         case (state_nxt)
            S_GAP:     tmr <= 16'(WRITE_GAP - 1);
            S_DRAIN:   tmr <= 16'(DRAIN_CYCLES - 1);
            S_WAIT_RD: tmr <= 16'(READ_LATENCY - 1);
            default:   tmr <= 16'd0;
         endcase
      end else if (tmr != 16'd0) begin
         tmr <= tmr - 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining <= 16'd0;
      end else if (state == S_IDLE && start) begin
         remaining <= count;
      end else if (accept) begin
         remaining <= remaining - 16'd1;
      end
   end

   // An empty batch reports a zero result rather than the previous one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_data <= 32'h0;
      end else if (state == S_CLEAR && remaining == 16'd0) begin
         res_data <= 32'h0;
      end else if (state == S_WAIT_RD && tmr == 16'd0) begin
         res_data <= avm_readdata;
      end
   end

`ifdef TERM_HOST_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STALL_W-1:0] stall_cnt;

   // Counts stall cycles already seen; the current stall cycle is the
   // TIMEOUT_CYCLES-th when the count reads TIMEOUT_CYCLES-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (state != S_FEED || s_valid) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign stall_hit = (state == S_FEED) && !s_valid
                      && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
   assign err       = stall_hit;
`else
   assign stall_hit = 1'b0;
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_term_host_master.sv
// Directed bench for term_host_master. A negedge monitor logs every bus
// strobe, result pulse and err pulse with its cycle number; each scenario
// pushes the events it expects and the two queues are compared afterwards.

module tb_term_host_master;

   localparam int WG = 7;
   localparam int DR = 12;
   localparam int RL = 11;
   localparam int TO = 16;
   localparam logic [31:0] DB = 32'hC0DE_0000;

   localparam logic [1:0] K_WR  = 2'd0;
   localparam logic [1:0] K_RD  = 2'd1;
   localparam logic [1:0] K_RES = 2'd2;
   localparam logic [1:0] K_ERR = 2'd3;

   typedef struct {
      int          cyc;
      logic [1:0]  kind;
      logic        addr;
      logic [31:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] count;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        avm_address;
   logic        avm_write;
   logic        avm_read;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        busy;
   logic        res_valid;
   logic [31:0] res_data;
   logic        err;

   int          cyc = 0;
   int          rd_at = -1000;
   logic [31:0] slave_val = 32'h0;
   int          checks = 0;
   int          failures = 0;
   int          viol = 0;
   ev_t         obs_q[$];
   ev_t         exp_q[$];
   bit          busy_log[int];

   term_host_master #(
      .WRITE_GAP(WG), .DRAIN_CYCLES(DR), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .count(count),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .busy(busy), .res_valid(res_valid), .res_data(res_data), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: data is valid only in the cycle whose closing edge is the
   // READ_LATENCY-th edge after the read strobe was sampled.
   assign avm_readdata = (cyc == rd_at + RL) ? slave_val : 32'hDEAD_BEEF;

   always @(negedge clk) begin
      busy_log[cyc] = busy;
      if (avm_write && avm_read) viol++;
      if (s_ready && !(avm_write && !avm_address)) viol++;
      if (avm_write)
         obs_q.push_back('{cyc, K_WR, avm_address, avm_writedata});
      else if (avm_read)
         obs_q.push_back('{cyc, K_RD, avm_address, 32'h0});
      if (res_valid) obs_q.push_back('{cyc, K_RES, 1'b0, res_data});
      if (err)       obs_q.push_back('{cyc, K_ERR, 1'b0, 32'h0});
      if (avm_read)  rd_at = cyc;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input int c, input logic [1:0] k, input logic a, input logic [31:0] d);
      exp_q.push_back('{c, k, a, d});
   endtask

   task automatic cmp_events(input string name);
      int n;
      chk({name, "_nevents"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_ev%0d_cyc", name, i),  64'(obs_q[i].cyc),  64'(exp_q[i].cyc));
         chk($sformatf("%s_ev%0d_kind", name, i), 64'(obs_q[i].kind), 64'(exp_q[i].kind));
         chk($sformatf("%s_ev%0d_addr", name, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
         chk($sformatf("%s_ev%0d_data", name, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_reset_values(input string name);
      chk({name, "_busy"},     64'(busy), 0);
      chk({name, "_write"},    64'(avm_write), 0);
      chk({name, "_read"},     64'(avm_read), 0);
      chk({name, "_address"},  64'(avm_address), 0);
      chk({name, "_wdata"},    64'(avm_writedata), 0);
      chk({name, "_s_ready"},  64'(s_ready), 0);
      chk({name, "_res_valid"}, 64'(res_valid), 0);
      chk({name, "_res_data"}, 64'(res_data), 0);
      chk({name, "_err"},      64'(err), 0);
   endtask

   // Drives one batch from the current cycle (i = 0 is the start cycle).
   // s_valid is low for i in [low_off, low_off+low_len); a second start with
   // count=1 is pulsed at i == restart_off; count changes after i = 0.
   task automatic run(input int cnt, input int low_off, input int low_len,
                      input int restart_off, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         start   = (i == 0) || (i == restart_off);
         count   = (i == 0) ? 16'(cnt) : 16'd1;
         s_valid = !(i >= low_off && i < low_off + low_len);
         s_data  = DB + 32'(cyc);
         step();
      end
      start   = 1'b0;
      s_valid = 1'b0;
   endtask

   initial begin
      int c;
      reset   = 1'b1;
      start   = 1'b0;
      count   = 16'd0;
      s_valid = 1'b0;
      s_data  = 32'h0;
      repeat (3) step();
      chk_reset_values("por");
      reset = 1'b0;

      // count=3, s_valid high; start on the very first cycle out of reset
      slave_val = 32'h4040_0000;
      c = cyc;
      expect_ev(c + 1,  K_WR, 1'b1, 32'h0);
      expect_ev(c + 2,  K_WR, 1'b0, DB + 32'(c + 2));
      expect_ev(c + 10, K_WR, 1'b0, DB + 32'(c + 10));
      expect_ev(c + 18, K_WR, 1'b0, DB + 32'(c + 18));
      expect_ev(c + 18 + DR + 1, K_RD, 1'b1, 32'h0);
      expect_ev(c + 18 + DR + 1 + RL + 1, K_RES, 1'b0, 32'h4040_0000);
      run(3, -1, 0, -1, 50);
      cmp_events("cnt3");
      chk("cnt3_res_held", 64'(res_data), 64'h4040_0000);
      chk("cnt3_idle_busy", 64'(busy), 0);

      // count=0: clear write, result 0 two cycles after start, no read
      c = cyc;
      expect_ev(c + 1, K_WR, 1'b1, 32'h0);
      expect_ev(c + 2, K_RES, 1'b0, 32'h0);
      run(0, -1, 0, -1, 6);
      cmp_events("cnt0");

      // count=2 with s_valid low for 5 FEED cycles before the second sample
      slave_val = 32'h3F80_0000;
      c = cyc;
      expect_ev(c + 1,  K_WR, 1'b1, 32'h0);
      expect_ev(c + 2,  K_WR, 1'b0, DB + 32'(c + 2));
      expect_ev(c + 15, K_WR, 1'b0, DB + 32'(c + 15));
      expect_ev(c + 28, K_RD, 1'b1, 32'h0);
      expect_ev(c + 40, K_RES, 1'b0, 32'h3F80_0000);
      run(2, 10, 5, -1, 46);
      cmp_events("stall5");

      // start with count=1 pulsed mid-batch must be ignored
      slave_val = 32'h1234_5678;
      c = cyc;
      expect_ev(c + 1,  K_WR, 1'b1, 32'h0);
      expect_ev(c + 2,  K_WR, 1'b0, DB + 32'(c + 2));
      expect_ev(c + 10, K_WR, 1'b0, DB + 32'(c + 10));
      expect_ev(c + 18, K_WR, 1'b0, DB + 32'(c + 18));
      expect_ev(c + 31, K_RD, 1'b1, 32'h0);
      expect_ev(c + 43, K_RES, 1'b0, 32'h1234_5678);
      run(3, -1, 0, 5, 50);
      cmp_events("restart");

      // reset while in WAIT_RD: immediate reset values, no result pulse
      slave_val = 32'h5555_AAAA;
      c = cyc;
      expect_ev(c + 1,  K_WR, 1'b1, 32'h0);
      expect_ev(c + 2,  K_WR, 1'b0, DB + 32'(c + 2));
      expect_ev(c + 10, K_WR, 1'b0, DB + 32'(c + 10));
      expect_ev(c + 18, K_WR, 1'b0, DB + 32'(c + 18));
      expect_ev(c + 31, K_RD, 1'b1, 32'h0);
      run(3, -1, 0, -1, 35);
      chk("wait_rd_busy", 64'(busy), 1);
      reset = 1'b1;
      #1;
      chk_reset_values("midrst");
      step();
      step();
      reset = 1'b0;
      slave_val = 32'h0BAD_F00D;
      c = cyc;
      expect_ev(c + 1,  K_WR, 1'b1, 32'h0);
      expect_ev(c + 2,  K_WR, 1'b0, DB + 32'(c + 2));
      expect_ev(c + 15, K_RD, 1'b1, 32'h0);
      expect_ev(c + 27, K_RES, 1'b0, 32'h0BAD_F00D);
      run(1, -1, 0, -1, 30);
      cmp_events("midrst");

      // long stall in FEED (16 cycles and beyond)
      slave_val = 32'h7F7F_FFFF;
      c = cyc;
      expect_ev(c + 1, K_WR, 1'b1, 32'h0);
      expect_ev(c + 2, K_WR, 1'b0, DB + 32'(c + 2));
`ifdef TERM_HOST_TIMEOUT_EN
      expect_ev(c + 10 + TO - 1, K_ERR, 1'b0, 32'h0);
      run(2, 10, 40, -1, 80);
      cmp_events("timeout");
      chk("timeout_busy_at_err", 64'(busy_log[c + 10 + TO - 1]), 1);
      chk("timeout_busy_after",  64'(busy_log[c + 10 + TO]), 0);
      chk("timeout_res_kept",    64'(res_data), 64'h0BAD_F00D);
`else
      expect_ev(c + 50, K_WR, 1'b0, DB + 32'(c + 50));
      expect_ev(c + 63, K_RD, 1'b1, 32'h0);
      expect_ev(c + 75, K_RES, 1'b0, 32'h7F7F_FFFF);
      run(2, 10, 40, -1, 80);
      cmp_events("nostall_to");
      chk("nostall_busy_late", 64'(busy_log[c + 49]), 1);
`endif

      chk("protocol_viol", 64'(viol), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
